// File: rtl/strassen_pkg.sv
// Shared types and tile-index helpers for the 4x4 tiled matrix-multiply scheduler.
package strassen_pkg;

    localparam int unsigned DATAWIDTH_DEF = 32;
    localparam int unsigned MAT_DIM       = 4;
    localparam int unsigned TILE_DIM      = 2;
    localparam int unsigned MAT_ELEMS     = MAT_DIM * MAT_DIM;
    localparam int unsigned TILE_ELEMS    = TILE_DIM * TILE_DIM;
    localparam int unsigned ISSUE_LAST    = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic valid;
        logic i;
        logic j;
        logic k;
    } tag_t;

    // Element index in the 4x4 matrix of element (r,c) inside tile (ti,tj).
    function automatic int unsigned mat_idx(input logic ti, input logic tj,
                                            input int unsigned r, input int unsigned c);
        return (TILE_DIM * 32'(ti) + r) * MAT_DIM + TILE_DIM * 32'(tj) + c;
    endfunction

    // Element index of (r,c) inside a 2x2 tile, x11 at index 0.
    function automatic int unsigned tile_idx(input int unsigned r, input int unsigned c);
        return r * TILE_DIM + c;
    endfunction

endpackage

// File: rtl/strassen_tag_pipe.sv
// Fixed-depth delay line carrying tile tags alongside the engine pipeline.
module strassen_tag_pipe
    import strassen_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  tag_t tag_i,
    output tag_t tag_o
);

    tag_t pipe_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned n = 0; n < DEPTH; n++) begin
                pipe_q[n] <= '0;
            end
        end else begin
            pipe_q[0] <= tag_i;
            for (int unsigned n = 1; n < DEPTH; n++) begin
                pipe_q[n] <= pipe_q[n-1];
            end
        end
    end

    assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/strassen_tile_sched.sv
// Schedules the eight 2x2 tile products of a 4x4 multiply onto an external
// tile engine and accumulates the returned tiles into C.
module strassen_tile_sched
    import strassen_pkg::*;
#(
    parameter int unsigned DATAWIDTH  = DATAWIDTH_DEF,
    parameter int unsigned ENGINE_LAT = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [MAT_ELEMS*DATAWIDTH-1:0]   a_mat,
    input  logic [MAT_ELEMS*DATAWIDTH-1:0]   b_mat,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [MAT_ELEMS*DATAWIDTH-1:0]   c_mat,
    output logic                             busy,
    output logic                             eng_rst,
    output logic [TILE_ELEMS*DATAWIDTH-1:0]  eng_a,
    output logic [TILE_ELEMS*DATAWIDTH-1:0]  eng_b,
    output logic                             eng_load,
    output logic                             eng_sel,
    input  logic [TILE_ELEMS*DATAWIDTH-1:0]  eng_c
);

    localparam int unsigned MW = MAT_ELEMS * DATAWIDTH;
    localparam int unsigned TW = TILE_ELEMS * DATAWIDTH;

    state_e          state_q, state_d;
    logic [2:0]      t_q, t_d;
    logic [MW-1:0]   a_q, b_q, c_q, c_d;
    logic [MW-1:0]   src_a, src_b;
    logic [TW-1:0]   eng_a_q, eng_a_d, eng_b_q, eng_b_d;
    logic            eng_load_q, eng_load_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q, busy_d;
    logic [DATAWIDTH-1:0] prod, cur;
    logic            accept;
    tag_t            tag_in, tag_out;

    assign accept = in_valid && in_ready_q;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            t_q     <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
        end
    end

    // Next-state logic; t advances one tile product per ISSUE cycle
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ISSUE;
                    t_d     = '0;
                end
            end
            ISSUE: begin
                if (t_q == 3'(ISSUE_LAST)) begin
                    state_d = DRAIN;
                end else begin
                    t_d = t_q + 3'd1;
                end
            end
            DRAIN: begin
                if (tag_out.valid && tag_out.i && tag_out.j && tag_out.k) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_valid_q && out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: next engine operands from (i,j,k)=t_d, and C accumulation on tag exit
    always_comb begin
        src_a       = (state_q == IDLE) ? a_mat : a_q;
        src_b       = (state_q == IDLE) ? b_mat : b_q;
        eng_load_d  = (state_d == ISSUE);
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
        eng_a_d     = '0;
        eng_b_d     = '0;
        c_d         = c_q;
        prod        = '0;
        cur         = '0;
        if (eng_load_d) begin
            for (int unsigned r = 0; r < TILE_DIM; r++) begin
                for (int unsigned c = 0; c < TILE_DIM; c++) begin
                    eng_a_d[tile_idx(r, c)*DATAWIDTH +: DATAWIDTH] =
                        src_a[mat_idx(t_d[2], t_d[0], r, c)*DATAWIDTH +: DATAWIDTH];
                    eng_b_d[tile_idx(r, c)*DATAWIDTH +: DATAWIDTH] =
                        src_b[mat_idx(t_d[0], t_d[1], r, c)*DATAWIDTH +: DATAWIDTH];
                end
            end
        end
        // eng_c is packed in reverse tile order: c11 on top, c22 at the bottom
        if (tag_out.valid) begin
            for (int unsigned r = 0; r < TILE_DIM; r++) begin
                for (int unsigned c = 0; c < TILE_DIM; c++) begin
                    prod = eng_c[(TILE_ELEMS - 1 - tile_idx(r, c))*DATAWIDTH +: DATAWIDTH];
                    cur  = c_q[mat_idx(tag_out.i, tag_out.j, r, c)*DATAWIDTH +: DATAWIDTH];
                    c_d[mat_idx(tag_out.i, tag_out.j, r, c)*DATAWIDTH +: DATAWIDTH] =
                        tag_out.k ? cur + prod : prod;
                end
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            eng_a_q     <= '0;
            eng_b_q     <= '0;
            eng_load_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            if (accept) begin
                a_q <= a_mat;
                b_q <= b_mat;
            end
            c_q         <= c_d;
            eng_a_q     <= eng_a_d;
            eng_b_q     <= eng_b_d;
            eng_load_q  <= eng_load_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign tag_in = '{valid: eng_load_q, i: t_q[2], j: t_q[1], k: t_q[0]};

    strassen_tag_pipe #(
        .DEPTH (ENGINE_LAT)
    ) u_tag_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .tag_i (tag_in),
        .tag_o (tag_out)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign c_mat     = c_q;
    assign eng_a     = eng_a_q;
    assign eng_b     = eng_b_q;
    assign eng_load  = eng_load_q;
    assign eng_sel   = 1'b0;
    assign eng_rst   = ~rst_n;

endmodule

// File: tb/tb_strassen_tile_sched.sv
// Directed bench for strassen_tile_sched with a two-stage 2x2 tile-multiply engine model.
module tb_strassen_tile_sched;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] a_mat;
    logic [511:0] b_mat;
    logic         out_valid;
    logic         out_ready;
    logic [511:0] c_mat;
    logic         busy;
    logic         eng_rst;
    logic [127:0] eng_a;
    logic [127:0] eng_b;
    logic         eng_load;
    logic         eng_sel;
    logic [127:0] eng_c;

    logic [127:0] eng_s1, eng_s2;
    int           n_asserts = 0;
    int           n_fails   = 0;
    int           cyc       = 0;

    strassen_tile_sched #(
        .DATAWIDTH  (32),
        .ENGINE_LAT (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_mat     (a_mat),
        .b_mat     (b_mat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c_mat     (c_mat),
        .busy      (busy),
        .eng_rst   (eng_rst),
        .eng_a     (eng_a),
        .eng_b     (eng_b),
        .eng_load  (eng_load),
        .eng_sel   (eng_sel),
        .eng_c     (eng_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // 2x2 product of x11,x12,x21,x22 (x11 lowest); result packed c11 on top
    function automatic logic [127:0] tile_mul(input logic [127:0] a, input logic [127:0] b);
        logic [127:0] p;
        logic [31:0]  s;
        p = '0;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
                s = '0;
                for (int m = 0; m < 2; m++) begin
                    s = s + a[(2*r+m)*32 +: 32] * b[(2*m+c)*32 +: 32];
                end
                p[(3-(2*r+c))*32 +: 32] = s;
            end
        end
        return p;
    endfunction

    always @(posedge clk) begin
        eng_s1 <= tile_mul(eng_a, eng_b);
        eng_s2 <= eng_s1;
    end
    assign eng_c = eng_s2;

    function automatic logic [511:0] mat_seq(input int start, input int stride);
        logic [511:0] v;
        for (int n = 0; n < 16; n++) v[n*32 +: 32] = 32'(start + stride*n);
        return v;
    endfunction

    function automatic logic [511:0] mat_ident(input int scale);
        logic [511:0] v;
        v = '0;
        for (int n = 0; n < 4; n++) v[(5*n)*32 +: 32] = 32'(scale);
        return v;
    endfunction

    function automatic logic [511:0] mat_fill(input int val);
        logic [511:0] v;
        for (int n = 0; n < 16; n++) v[n*32 +: 32] = 32'(val);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one job, wait for its result, then consume it; lat counts cycles accept->out_valid
    task automatic run_job(input logic [511:0] a, input logic [511:0] b,
                           output logic [511:0] c, output int lat);
        a_mat = a;
        b_mat = b;
        in_valid = 1'b1;
        lat = 0;
        while (!in_ready && lat < 40) begin
            step();
            lat++;
        end
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 60) begin
            step();
            lat++;
        end
        c = c_mat;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    logic [511:0] res, snap;
    logic [511:0] exp_b;
    logic [127:0] exp_ta, exp_tb;
    logic [511:0] ja[3], jb[3], jc[3];
    int           lat, n, loads, highs;
    int           acc[3];

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a_mat = '0; b_mat = '0;
        step();
        check("eng_rst_in_reset", eng_rst, 1);
        step();
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_eng_load", eng_load, 0);
        check("rst_c_mat", c_mat, 0);
        check("rst_eng_ab", {eng_a, eng_b}, 0);
        check("eng_rst_released", eng_rst, 0);
        check("eng_sel", eng_sel, 0);

        // Identity * B: first tile operands and exact latency
        exp_b = mat_seq(1, 1);
        a_mat = mat_ident(1); b_mat = exp_b; in_valid = 1'b1;
        check("accept_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        exp_ta = {32'd1, 32'd0, 32'd0, 32'd1};
        exp_tb = {32'd6, 32'd5, 32'd2, 32'd1};
        check("issue0_busy", busy, 1);
        check("issue0_load", eng_load, 1);
        check("issue0_eng_a", eng_a, exp_ta);
        check("issue0_eng_b", eng_b, exp_tb);
        n = 1; loads = 1;
        while (!out_valid && n < 40) begin
            step();
            n++;
            if (eng_load) loads++;
        end
        check("ident_out_cycle", n, 11);
        check("ident_load_count", loads, 8);
        check("ident_c", c_mat, exp_b);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("ident_handshake_ov", out_valid, 0);
        check("ident_handshake_busy", busy, 0);

        // All-2 matrices
        run_job(mat_fill(2), mat_fill(2), res, lat);
        check("all2_lat", lat, 11);
        check("all2_c", res, mat_fill(16));

        // Wrap-around accumulation
        a_mat = '0; b_mat = '0;
        res = '0; res[31:0] = 32'h7FFF_FFFF;
        snap = '0; snap[31:0] = 32'd2;
        exp_b = '0; exp_b[31:0] = 32'hFFFF_FFFE;
        run_job(res, snap, res, lat);
        check("wrap_c", res, exp_b);

        // Busy ignores in_valid; DONE holds with out_ready low
        a_mat = mat_fill(2); b_mat = mat_fill(2); in_valid = 1'b1;
        step();
        a_mat = mat_ident(1); b_mat = mat_fill(3);
        step();
        check("busy_not_ready", in_ready, 0);
        n = 2;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
        check("hold_lat", n, 11);
        for (int h = 0; h < 5; h++) begin
            step();
            check("hold_out_valid", out_valid, 1);
            check("hold_c", c_mat, mat_fill(16));
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("no_accept_at_done_exit", busy, 0);
        check("idle_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        check("accept_next_cycle", busy, 1);
        n = 1;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
        check("second_job_c", c_mat, mat_fill(3));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Reset in ISSUE cycle 4
        a_mat = mat_fill(2); b_mat = mat_fill(2); in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step(); step();
        check("mid_issue_load", eng_load, 1);
        rst_n = 1'b0;
        #1;
        check("mid_reset_eng_rst", eng_rst, 1);
        step();
        rst_n = 1'b1;
        check("mid_reset_busy", busy, 0);
        check("mid_reset_ready", in_ready, 1);
        check("mid_reset_ov", out_valid, 0);
        check("mid_reset_load", eng_load, 0);
        check("mid_reset_c", c_mat, 0);
        highs = 0;
        for (int w = 0; w < 15; w++) begin
            step();
            if (out_valid) highs++;
        end
        check("no_result_after_reset", highs, 0);
        run_job(mat_ident(1), mat_seq(1, 1), res, lat);
        check("post_reset_lat", lat, 11);
        check("post_reset_c", res, mat_seq(1, 1));

        // Back-to-back jobs with in_valid and out_ready held high
        ja[0] = mat_ident(2); jb[0] = mat_seq(1, 1);  jc[0] = mat_seq(2, 2);
        ja[1] = mat_fill(1);  jb[1] = mat_ident(1);   jc[1] = mat_fill(1);
        ja[2] = mat_seq(1, 1); jb[2] = mat_ident(1);  jc[2] = mat_seq(1, 1);
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            a_mat = ja[j];
            b_mat = jb[j];
            n = 0;
            while (!in_ready && n < 40) begin
                step();
                n++;
            end
            acc[j] = cyc;
            step();
            n = 1;
            while (!out_valid && n < 40) begin
                step();
                n++;
            end
            check("b2b_lat", n, 11);
            check("b2b_c", c_mat, jc[j]);
        end
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        check("b2b_period_01", acc[1] - acc[0], 12);
        check("b2b_period_12", acc[2] - acc[1], 12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
